// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a single full-subtractor cell with a registered borrow,
// one bit per clock (LSB first), with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b, r_diff;
  logic               r_brw, r_bout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_d, w_bo, w_last;

  assign w_d    = r_a[0] ^ r_b[0] ^ r_brw;
  assign w_bo   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SHIFT;
      SHIFT:   if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The minuend register doubles as the result register: each difference bit
  // enters the MSB slot vacated by the right shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a   <= a;
          r_b   <= b;
          r_brw <= bin;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_a   <= {w_d, r_a[WIDTH-1:1]};
          r_b   <= r_b >> 1;
          r_brw <= w_bo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff <= {w_d, r_a[WIDTH-1:1]};
            r_bout <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases and random traffic at WIDTH=8,
// exhaustive sweep at WIDTH=4, against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, bin = 1'b0, bout;
  logic [7:0] a = '0, b = '0, diff;
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, bin4 = 1'b0, bout4;
  logic [3:0] a4 = '0, b4 = '0, diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .bout(bout4)
  );

  // Reference: plain integer arithmetic, result {bout, diff}.
  function automatic logic [8:0] ref_sub(input int w, input int ra, input int rb, input int rbin);
    int d;
    d = (ra - rb - rbin) & ((1 << w) - 1);
    return {(ra < rb + rbin) ? 1'b1 : 1'b0, 8'(d)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one operand set into the 8-bit DUT; returns edges from accept to out_valid.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
  endtask

  task automatic issue4(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin, output int lat);
    int w;
    w = 0;
    while (!in_ready4 && w < 20) begin step(); w++; end
    a4 = ta; b4 = tb_; bin4 = tbin; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 0;
    while (!out_valid4 && lat < 40) begin step(); lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h want 00", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
    end
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b want 1", in_ready4); end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    issue8(8'h5A, 8'h3C, 1'b0, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++; if (diff !== 8'h1E) begin errors++; $display("FAIL basic_diff: got %h want 1e", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b want 0", bout); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_next: got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] ta [3] = '{8'h00, 8'h80, 8'h00};
    logic [7:0] tbv[3] = '{8'h01, 8'h7F, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ed [3] = '{8'hFF, 8'h00, 8'h00};
    logic       eb [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue8(ta[i], tbv[i], tc[i], lat);
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL wrap_diff[%0d]: got %h want %h", i, diff, ed[i]); end
      checks++; if (bout !== eb[i]) begin errors++; $display("FAIL wrap_bout[%0d]: got %b want %b", i, bout, eb[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    issue8(8'h10, 8'h03, 1'b0, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d want 8", lat); end
    in_valid = 1'b1; a = 8'hFF; b = 8'h0F; bin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h0D || bout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b diff=%h bout=%b want ov=1 ir=0 diff=0d bout=0",
                 i, out_valid, in_ready, diff, bout);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    checks++; if (diff !== 8'h0D) begin errors++; $display("FAIL bp_diff_kept: got %h want 0d", diff); end
    issue8(8'hFF, 8'h0F, 1'b0, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_next_latency: got %0d want 8", lat); end
    checks++; if (diff !== 8'hF0 || bout !== 1'b0) begin errors++; $display("FAIL bp_next_result: got %h/%b want f0/0", diff, bout); end
    step();
  endtask

  task automatic test_midreset();
    int lat;
    logic seen;
    out_ready = 1'b1;
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++; if (diff !== 8'h00 || bout !== 1'b0) begin errors++; $display("FAIL midrst_result: got %h/%b want 00/0", diff, bout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valid: got %b want 0", seen); end
    issue8(8'h09, 8'h04, 1'b1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
    checks++; if (diff !== 8'h04 || bout !== 1'b0) begin errors++; $display("FAIL midrst_next_result: got %h/%b want 04/0", diff, bout); end
    step();
  endtask

  task automatic test_random8();
    int lat, k;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] exp;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = ref_sub(8, int'(ra), int'(rb), int'(rc));
      out_ready = 1'b0;
      issue8(ra, rb, rc, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL rand8_latency[%0d]: got %0d want 8", i, lat); end
      k = $urandom_range(0, 3);
      repeat (k) step();
      checks++;
      if (out_valid !== 1'b1 || diff !== exp[7:0] || bout !== exp[8]) begin
        errors++;
        $display("FAIL rand8[%0d] %h-%h-%b: got ov=%b %h/%b want 1 %h/%b", i, ra, rb, rc, out_valid, diff, bout, exp[7:0], exp[8]);
      end
      out_ready = 1'b1;
      step();
    end
  endtask

  task automatic test_sweep4();
    int lat, k;
    logic [8:0] exp;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          exp = ref_sub(4, ia, ib, ic);
          out_ready4 = 1'b0;
          issue4(4'(ia), 4'(ib), 1'(ic), lat);
          checks++; if (lat !== 4) begin errors++; $display("FAIL sweep4_latency %0d-%0d-%0d: got %0d want 4", ia, ib, ic, lat); end
          k = $urandom_range(0, 2);
          repeat (k) step();
          checks++;
          if (out_valid4 !== 1'b1 || diff4 !== exp[3:0] || bout4 !== exp[8]) begin
            errors++;
            $display("FAIL sweep4 %0d-%0d-%0d: got ov=%b %h/%b want 1 %h/%b", ia, ib, ic, out_valid4, diff4, bout4, exp[3:0], exp[8]);
          end
          out_ready4 = 1'b1;
          step();
        end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_midreset();
    test_random8();
    test_sweep4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit unsigned subtractor built around a single full-subtractor cell (Diff = A^B^Bin, Bout = ~A&B | ~(A^B)&Bin) and a registered borrow.
- Accepts two operands and a borrow-in over a valid/ready handshake.
- Processes one bit per clock, LSB first.
- Presents difference and borrow-out over a second valid/ready handshake.
- Serves as the area-minimal subtract stage wherever the building-block datapaths trade latency for gates.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set a/b/bin valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
bin  input  1  initial borrow-in
out_valid  output  1  diff/bout hold a completed result
out_ready  input  1  consumer accepts result
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: takes effect at any clk edge with rst=1, including mid-operation.
  - The current operation is aborted and discarded.
  - State goes to IDLE; shift registers, bit counter and borrow register clear.
  - out_valid=0, diff=0, bout=0; in_ready=1 from the first cycle after reset.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On an edge with in_valid & in_ready: load a_sr<=a, b_sr<=b, brw<=bin, cnt<=0; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, once per cycle:
  - d = a_sr[0]^b_sr[0]^brw.
  - bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&brw).
  - a_sr and b_sr shift right by one.
  - Result register r shifts right with d entering the MSB.
  - brw<=bo; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: diff<={d, r[WIDTH-1:1]}, bout<=bo, go to DONE.
- Latency: exactly WIDTH cycles. If the accept edge is edge 0, out_valid is first high after edge WIDTH.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH shifts, output handshake; IDLE is re-entered before the next accept).
- DONE:
  - diff/bout held stable while out_valid=1.
  - On an edge with out_valid & out_ready: go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle result-to-accept pass-through.
- in_valid, a, b and bin are ignored outside IDLE and are never sampled mid-operation.
- out_ready is ignored outside DONE.
- diff/bout are written only on the SHIFT->DONE transition.
  - They keep the previous result through IDLE and SHIFT.
  - Consumers must qualify them with out_valid.
- Arithmetic: unsigned modulo 2^WIDTH. bout equals the borrow out of the MSB cell.
  - a=b with bin=0 gives diff=0, bout=0.
  - The max-borrow case a=0, b=all-ones, bin=1 gives diff=0, bout=1.
- Counter width is clog2(WIDTH). It must not wrap before the terminal compare.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 and random operands -> out_valid=0, diff=0x00, bout=0; in_ready=1 on the first cycle after rst drops.
2. Basic, WIDTH=8: a=0x5A, b=0x3C, bin=0, out_ready=1 -> diff=0x1E, bout=0; out_valid first high exactly 8 cycles after the accept edge, high for one cycle; in_ready high the next cycle.
3. Wrap/borrow cases:
   - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
   - a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
   - a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
4. Backpressure:
   - Complete a=0x10, b=0x03, bin=0 with out_ready=0 for 5 cycles while in_valid=1 with a=0xFF -> diff stays 0x0D, bout=0, out_valid=1, in_ready=0 throughout.
   - Raise out_ready -> return to IDLE; the 0xFF operand is accepted only after in_ready reasserts.
5. Mid-operation reset: accept a=0xAA, b=0x55, assert rst on the 3rd SHIFT cycle -> out_valid never rises, diff=0x00, in_ready=1 after reset. Next operation a=0x09, b=0x04, bin=1 -> diff=0x04, bout=0 after 8 cycles.
6. Exhaustive sweep, WIDTH=4: all 512 (a,b,bin) combinations with random out_ready stalls -> every diff/bout matches (a-b-bin) mod 16 and (a<b+bin); latency is always 4 cycles.
